// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
//   Bank of N_CH independent programmable clock dividers sharing one write
//   port, one phase-align strobe and one count readback port.
//
//   Each channel counts up from 0 to its divisor and then wraps to 0. The
//   cycle in which cnt == div and the channel is enabled is the terminal
//   count (TC). A TC produces:
//     - tick[c] high for the following cycle.
//     - In toggle mode (mode=0), clk_out[c] inverts. The output period is
//       2*(div+1) cycles.
//     - In pulse mode (mode=1), clk_out[c] follows tick[c].
//
// Ports
//   clk       in   system clock; all state changes on the rising edge
//   rst       in   asynchronous, active-high reset
//   en        in   [N_CH]  per-channel count enable
//   sync_clr  in   clears every counter, clk_out and tick (phase align)
//   wr_en     in   configuration write strobe
//   wr_ch     in   [4]     write target channel; values >= N_CH are ignored
//   wr_div    in   [CNT_W] divisor to load
//   wr_mode   in   mode to load: 0 = toggle, 1 = pulse
//   rd_ch     in   [4]     channel whose counter appears on rd_cnt
//   clk_out   out  [N_CH]  registered divided outputs
//   tick      out  [N_CH]  registered one-cycle terminal-count strobes
//   rd_cnt    out  [CNT_W] registered cnt[rd_ch]; reads 0 for rd_ch >= N_CH
// ---------------------------------------------------------------------------
module clk_div_multi #(
  parameter int               N_CH    = 4,
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(32'h000C_B735)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  en,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [3:0]       wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  input  logic             wr_mode,
  input  logic [3:0]       rd_ch,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [CNT_W-1:0] rd_cnt
);

  // Per-channel counters, exported from the channel slices for readback.
  logic [CNT_W-1:0] cnt_all [N_CH];

  // Readback table padded to the full 4-bit select range, so an
  // out-of-range rd_ch naturally selects a zero entry.
  logic [CNT_W-1:0] cnt_pad [16];

  // -------------------------------------------------------------------------
  // Channel slices
  // -------------------------------------------------------------------------
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] div_r;
    logic             mode_r;
    logic             lvl_r;    // toggle-mode output level
    logic             tick_r;
    logic             out_r;

    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] div_n;
    logic             mode_n;
    logic             lvl_n;
    logic             tick_n;

    logic             wr_hit;
    logic             tc;

    // Comparing against the channel index alone is enough: no slice
    // exists for an index >= N_CH, so such writes match nothing.
    assign wr_hit = wr_en && (wr_ch == 4'(c));
    assign tc     = en[c] && (cnt_r == div_r);

    always_comb begin
      cnt_n  = cnt_r;
      div_n  = div_r;
      mode_n = mode_r;
      lvl_n  = lvl_r;
      tick_n = 1'b0;

      // A configuration write always lands, even alongside sync_clr.
      if (wr_hit) begin
        div_n  = wr_div;
        mode_n = wr_mode;
      end

      if (sync_clr) begin
        cnt_n = '0;
        lvl_n = 1'b0;
      end else if (wr_hit) begin
        // The write restarts the period. A coincident TC is dropped
        // (no tick, no toggle), and the toggle level is kept.
        cnt_n = '0;
      end else if (en[c]) begin
        if (tc) begin
          cnt_n  = '0;
          tick_n = 1'b1;
          if (!mode_r) begin
            lvl_n = ~lvl_r;
          end
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_r  <= '0;
        div_r  <= DEF_DIV;
        mode_r <= 1'b0;
        lvl_r  <= 1'b0;
        tick_r <= 1'b0;
        out_r  <= 1'b0;
      end else begin
        cnt_r  <= cnt_n;
        div_r  <= div_n;
        mode_r <= mode_n;
        lvl_r  <= lvl_n;
        tick_r <= tick_n;
        // The output is registered from next-state values so it lines up
        // with tick. In pulse mode it mirrors tick; in toggle mode it
        // carries the level.
        out_r  <= mode_n ? tick_n : lvl_n;
      end
    end

    assign cnt_all[c] = cnt_r;
    assign clk_out[c] = out_r;
    assign tick[c]    = tick_r;
  end

  // -------------------------------------------------------------------------
  // Count readback
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cnt_pad[i] = '0;
    end
    for (int i = 0; i < N_CH; i++) begin
      cnt_pad[i] = cnt_all[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
    end else begin
      rd_cnt <= cnt_pad[rd_ch];
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
//   Self-checking bench for clk_div_multi. A behavioural model tracks each
//   channel's phase within its period and its toggle level. Every cycle, the
//   bench compares clk_out, tick and rd_cnt against that model. Directed
//   scenarios come first, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] DEF_DIV = 32'd9;

  logic             clk;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             sync_clr;
  logic             wr_en;
  logic [3:0]       wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_mode;
  logic [3:0]       rd_ch;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [CNT_W-1:0] rd_cnt;

  clk_div_multi #(
    .N_CH   (N_CH),
    .CNT_W  (CNT_W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync_clr(sync_clr),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .wr_mode (wr_mode),
    .rd_ch   (rd_ch),
    .clk_out (clk_out),
    .tick    (tick),
    .rd_cnt  (rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Model state. phase = cycles elapsed within the current period.
  int unsigned m_phase [N_CH];
  int unsigned m_div   [N_CH];
  bit          m_pulse [N_CH];
  bit          m_level [N_CH];
  bit          m_tick  [N_CH];
  logic [31:0] m_rd;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_phase[c] = 0;
      m_div[c]   = DEF_DIV;
      m_pulse[c] = 1'b0;
      m_level[c] = 1'b0;
      m_tick[c]  = 1'b0;
    end
    m_rd = 0;
  endfunction

  // One rising edge, applied to the inputs currently being driven.
  function automatic void model_edge();
    bit hit;
    bit at_end;
    m_rd = (rd_ch < N_CH) ? m_phase[rd_ch] : 32'd0;
    for (int c = 0; c < N_CH; c++) begin
      hit    = wr_en && (int'(wr_ch) == c);
      at_end = en[c] && (m_phase[c] == m_div[c]);
      m_tick[c] = 1'b0;
      if (sync_clr) begin
        m_phase[c] = 0;
        m_level[c] = 1'b0;
      end else if (hit) begin
        m_phase[c] = 0;
      end else if (en[c]) begin
        if (at_end) begin
          m_phase[c] = 0;
          m_tick[c]  = 1'b1;
          if (!m_pulse[c]) m_level[c] = !m_level[c];
        end else begin
          m_phase[c] = m_phase[c] + 1;
        end
      end
      if (hit) begin
        m_div[c]   = wr_div;
        m_pulse[c] = wr_mode;
      end
    end
  endfunction

  task automatic compare_all();
    logic [31:0] exp_out;
    logic [31:0] exp_tick;
    exp_out  = '0;
    exp_tick = '0;
    for (int c = 0; c < N_CH; c++) begin
      exp_tick[c] = m_tick[c];
      exp_out[c]  = m_pulse[c] ? m_tick[c] : m_level[c];
    end
    check_val("clk_out", 32'(clk_out), exp_out);
    check_val("tick", 32'(tick), exp_tick);
    check_val("rd_cnt", rd_cnt, m_rd);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    sync_clr = 1'b0;
    wr_en    = 1'b0;
    wr_ch    = 4'd0;
    wr_div   = '0;
    wr_mode  = 1'b0;
  endtask

  task automatic do_write(input int ch, input int unsigned dv, input bit md);
    wr_en   = 1'b1;
    wr_ch   = 4'(ch);
    wr_div  = dv;
    wr_mode = md;
    step();
    idle_inputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    en       = '0;
    rd_ch    = 4'd0;
    idle_inputs();
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_val("rst_clk_out", 32'(clk_out), 32'd0);
    check_val("rst_tick", 32'(tick), 32'd0);
    check_val("rst_rd_cnt", rd_cnt, 32'd0);
    rst = 1'b0;

    // Reset divisor: enable all and watch the first TC at DEF_DIV.
    en = '1;
    run(24);

    // ch0 toggle div=3, ch1 pulse div=2.
    do_write(0, 3, 1'b0);
    do_write(1, 2, 1'b1);
    rd_ch = 4'd0;
    run(26);
    rd_ch = 4'd1;
    run(6);

    // div=0 on ch2, then freeze it.
    rd_ch = 4'd2;
    do_write(2, 0, 1'b0);
    run(5);
    en[2] = 1'b0;
    run(4);
    en[2] = 1'b1;
    run(2);

    // Phase align two running channels.
    do_write(0, 5, 1'b0);
    do_write(1, 7, 1'b0);
    run(11);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    run(20);

    // Write landing exactly on ch0 TC.
    found = 1'b0;
    rd_ch = 4'd0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_phase[0] == m_div[0]) found = 1'b1;
      else step();
    end
    check_val("tc_reached", 32'(found), 32'd1);
    do_write(0, 4, 1'b0);
    check_val("tc_write_tick", 32'(tick[0]), 32'd0);
    run(6);

    // Out-of-range channel write is ignored.
    do_write(N_CH, 1, 1'b1);
    run(12);

    // Asynchronous reset mid-count with ch0 at phase 2, level high.
    do_write(0, 5, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_phase[0] == 2 && m_level[0]) found = 1'b1;
      else step();
    end
    check_val("mid_count_reached", 32'(found), 32'd1);
    rst = 1'b1;
    #2;
    check_val("async_clk_out", 32'(clk_out), 32'd0);
    check_val("async_tick", 32'(tick), 32'd0);
    check_val("async_rd_cnt", rd_cnt, 32'd0);
    model_reset();
    #1;
    rst = 1'b0;
    run(25);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) en[c] = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 49) == 0);
      wr_en    = ($urandom_range(0, 9) == 0);
      wr_ch    = 4'($urandom_range(0, 5));
      wr_div   = $urandom_range(0, 7);
      wr_mode  = 1'($urandom_range(0, 1));
      rd_ch    = 4'($urandom_range(0, 5));
      step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: counter and divisor width.
REQ-003 SHALL have parameter DEF_DIV, default 32'h000C_B735: reset divisor of every channel (60 Hz toggle at 100 MHz).
REQ-004 SHALL have port clk  input  1: system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  N_CH: per-channel count enable.
REQ-007 SHALL have port sync_clr  input  1: global phase-align strobe.
REQ-008 SHALL have port wr_en  input  1: configuration write strobe.
REQ-009 SHALL have port wr_ch  input  4: target channel of write.
REQ-010 SHALL have port wr_div  input  CNT_W: new divisor.
REQ-011 SHALL have port wr_mode  input  1: new mode, 0 = toggle, 1 = pulse.
REQ-012 SHALL have port rd_ch  input  4: channel selected for count readback.
REQ-013 SHALL have port clk_out  output  N_CH: per-channel divided output, registered.
REQ-014 SHALL have port tick  output  N_CH: per-channel one-cycle terminal-count strobe, registered.
REQ-015 SHALL have port rd_cnt  output  CNT_W: counter value of channel rd_ch, registered.

Function
REQ-016 Each channel SHALL hold a divisor register div[c], a mode bit mode[c], and a counter cnt[c].
REQ-017 With en[c]=1, cnt[c] SHALL increment by 1 per cycle; when cnt[c]==div[c] it SHALL wrap to 0 on the next edge (terminal count, TC).
REQ-018 At TC, tick[c] SHALL be 1 for exactly the following cycle; it is 0 otherwise.
REQ-019 Toggle mode: at TC, clk_out[c] SHALL invert; output period = 2*(div+1) cycles, 50% duty.
REQ-020 Pulse mode: clk_out[c] SHALL equal tick[c] (high one cycle per div+1 cycles).
REQ-021 div[c]=0 SHALL give TC every cycle: tick constantly 1, toggle output = clk/2.
REQ-022 en[c]=0 SHALL freeze cnt[c] and clk_out[c] (toggle mode) and force tick[c] to 0; pulse-mode clk_out[c] SHALL be 0.
REQ-023 wr_en with wr_ch<N_CH SHALL load div, mode for that channel and clear its cnt to 0 on the same edge; the clk_out level is kept in toggle mode.
REQ-024 wr_en with wr_ch>=N_CH SHALL be ignored with no state change.
REQ-025 A write coinciding with TC on the same channel SHALL suppress that channel's tick and toggle; the write wins.
REQ-026 sync_clr SHALL clear all cnt, clk_out, and tick to 0 on the next edge, regardless of en.
REQ-027 sync_clr together with wr_en SHALL apply the write's div/mode and sync_clr's clears; sync_clr has priority on outputs.
REQ-028 rd_cnt SHALL present cnt[rd_ch] sampled one cycle earlier (latency 1); rd_ch>=N_CH SHALL read 0.
REQ-029 Counter arithmetic SHALL be unsigned CNT_W bits; since TC bounds cnt, it SHALL never overflow past div.

Reset
REQ-030 rst=1 SHALL immediately set every cnt to 0, div to DEF_DIV, mode to 0, clk_out to 0, tick to 0, and rd_cnt to 0.
REQ-031 After rst deasserts, counting SHALL begin on the first rising edge with en[c]=1; reset mid-period SHALL discard partial counts.

Verification
REQ-032 Write ch0 div=3 mode=0, en=1 -> clk_out[0] toggles every 4 cycles (period 8), tick[0] pulses every 4 cycles.
REQ-033 Write ch1 div=2 mode=1 -> clk_out[1]=tick[1], high 1 cycle in every 3; ch0 timing is unaffected.
REQ-034 Write div=0 -> tick stays 1 and toggle output alternates every cycle; then en=0 -> tick=0 and cnt/clk_out are frozen.
REQ-035 ch0 div=5 and ch1 div=7 running; assert sync_clr -> both cnt=0 and clk_out=0 next cycle, with TC edges realigned afterwards.
REQ-036 Write at the cycle where cnt==div -> no tick; cnt=0 and the new period starts; a write with wr_ch=N_CH leaves all state unchanged.
REQ-037 Assert rst asynchronously mid-count (cnt=2, clk_out=1) -> all outputs 0 before the next edge, div reads back as DEF_DIV behaviour.
